// File: rtl/page_table_walker_if.sv
// Walker bus bundle: miss request, PTE read port, tag-RAM fill port and completion.
// master: the walker side; slave: requester / memory / tag-RAM side.
// Ports: req_*, root_ppn (miss request), mem_* (PTE read), fill_* (tag RAM), done/fault.
interface page_table_walker_if #(
    parameter int TAG_RAM_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH          = 20,
    parameter int PAYLOAD_WIDTH      = 32
);
    logic                          req_valid;
    logic                          req_ready;
    logic [19:0]                   req_vpn;
    logic [19:0]                   root_ppn;
    logic                          mem_req_valid;
    logic                          mem_req_ready;
    logic [31:0]                   mem_addr;
    logic                          mem_resp_valid;
    logic [31:0]                   mem_rdata;
    logic                          fill_valid;
    logic                          fill_we;
    logic [TAG_RAM_ADDR_WIDTH-1:0] fill_idx;
    logic [TAG_WIDTH-1:0]          fill_tag;
    logic [PAYLOAD_WIDTH-1:0]      fill_payload;
    logic                          done;
    logic                          fault;

    modport master (
        input  req_valid, req_vpn, root_ppn, mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_addr,
        output fill_valid, fill_we, fill_idx, fill_tag, fill_payload, done, fault
    );

    modport slave (
        output req_valid, req_vpn, root_ppn, mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_addr,
        input  fill_valid, fill_we, fill_idx, fill_tag, fill_payload, done, fault
    );
endinterface

// File: rtl/page_table_walker.sv
// Two-level page-table walker: reads L1 (and L0 if pointed to) PTEs, then fills the tag RAM or faults.
// Latency: done 3 cycles after accept for L1 leaf/fault, 5 for a two-level walk (no memory stalls).
// Backpressure: one read outstanding; mem_addr held while mem_req_ready is low; req_ready low while busy.
// Ports: clk, reset (async, active-high), bus (page_table_walker_if.master). All outputs registered.
module page_table_walker #(
    parameter int TAG_RAM_ADDR_WIDTH = 6,
    parameter int TAG_WIDTH          = 20,
    parameter int PAYLOAD_WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    page_table_walker_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_WAIT,
        S_L0_REQ,
        S_L0_WAIT,
        S_DONE
    } state_t;

    state_t                        state_q;
    logic [19:0]                   vpn_q;
    logic                          req_ready_q;
    logic                          mem_req_valid_q;
    logic [31:0]                   mem_addr_q;
    logic                          fill_valid_q;
    logic                          fill_we_q;
    logic [TAG_RAM_ADDR_WIDTH-1:0] fill_idx_q;
    logic [TAG_WIDTH-1:0]          fill_tag_q;
    logic [PAYLOAD_WIDTH-1:0]      fill_payload_q;
    logic                          done_q;
    logic                          fault_q;

    // PTE decode of the response word; only consumed in the WAIT states.
    logic        pte_v, pte_r, pte_w, pte_x;
    logic        pte_bad_d;
    logic        pte_ptr_d;
    logic        descend_d;
    logic        fault_d;
    logic [19:0] leaf_ppn_d;

    always_comb begin
        pte_v      = bus.mem_rdata[0];
        pte_r      = bus.mem_rdata[1];
        pte_w      = bus.mem_rdata[2];
        pte_x      = bus.mem_rdata[3];
        pte_bad_d  = !pte_v || (pte_w && !pte_r);
        pte_ptr_d  = pte_v && !pte_r && !pte_w && !pte_x;
        descend_d  = 1'b0;
        fault_d    = 1'b0;
        leaf_ppn_d = bus.mem_rdata[31:12];
        if (pte_bad_d) begin
            fault_d = 1'b1;
        end else if (pte_ptr_d) begin
            // A pointer is only legal at L1; at L0 there is no further level.
            if (state_q == S_L1_WAIT) descend_d = 1'b1;
            else                      fault_d   = 1'b1;
        end else if (state_q == S_L1_WAIT) begin
            // Superpage leaf: low PPN bits must be zero, VPN0 supplies them instead.
            if (bus.mem_rdata[21:12] != 10'd0) fault_d = 1'b1;
            else leaf_ppn_d = {bus.mem_rdata[31:22], vpn_q[9:0]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            vpn_q           <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            fill_valid_q    <= 1'b0;
            fill_we_q       <= 1'b0;
            fill_idx_q      <= '0;
            fill_tag_q      <= '0;
            fill_payload_q  <= '0;
            done_q          <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        // root_ppn is only needed for the L1 address, so it is
                        // captured directly into the held request address.
                        vpn_q           <= bus.req_vpn;
                        mem_addr_q      <= {bus.root_ppn, bus.req_vpn[19:10], 2'b00};
                        mem_req_valid_q <= 1'b1;
                        req_ready_q     <= 1'b0;
                        state_q         <= S_L1_REQ;
                    end
                end
                S_L1_REQ, S_L0_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                    end
                end
                S_L1_WAIT, S_L0_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (descend_d) begin
                            mem_addr_q      <= {bus.mem_rdata[31:12], vpn_q[9:0], 2'b00};
                            mem_req_valid_q <= 1'b1;
                            state_q         <= S_L0_REQ;
                        end else begin
                            done_q       <= 1'b1;
                            fault_q      <= fault_d;
                            fill_valid_q <= !fault_d;
                            fill_we_q    <= !fault_d;
                            if (!fault_d) begin
                                fill_idx_q     <= vpn_q[TAG_RAM_ADDR_WIDTH-1:0];
                                fill_tag_q     <= vpn_q;
                                fill_payload_q <= {leaf_ppn_d, bus.mem_rdata[11:0]};
                            end
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q       <= 1'b0;
                    fault_q      <= 1'b0;
                    fill_valid_q <= 1'b0;
                    fill_we_q    <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.fill_valid    = fill_valid_q;
    assign bus.fill_we       = fill_we_q;
    assign bus.fill_idx      = fill_idx_q;
    assign bus.fill_tag      = fill_tag_q;
    assign bus.fill_payload  = fill_payload_q;
    assign bus.done          = done_q;
    assign bus.fault         = fault_q;
endmodule

// File: tb/tb_page_table_walker.sv
// Testbench for page_table_walker: directed vector table, hand-written corner sequences,
// and randomized walks checked against a behavioural reference model.
// Acts as requester, memory responder (stalls, delays, stray responses) and tag-RAM observer.
module tb_page_table_walker;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    page_table_walker_if #(.TAG_RAM_ADDR_WIDTH(6), .TAG_WIDTH(20), .PAYLOAD_WIDTH(32)) bus ();

    page_table_walker #(.TAG_RAM_ADDR_WIDTH(6), .TAG_WIDTH(20), .PAYLOAD_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Observations of the most recent walk.
    int          r_nreq, r_lat;
    logic [31:0] r_addr1, r_addr2, r_payload;
    logic        r_fault, r_we, r_fv, r_stable, r_spur, r_busy_ok, r_overlap, r_timeout;
    logic [5:0]  r_idx;
    logic [19:0] r_tag;

    typedef struct {
        logic [19:0] vpn;
        logic [19:0] root;
        logic [31:0] l1;
        logic [31:0] l0;
        int          stall;
        logic [31:0] addr1;
        logic [31:0] addr2;
        int          nreq;
        int          lat;
        logic        fault;
        logic [31:0] payload;
        logic [5:0]  idx;
        logic [19:0] tag;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},     32'(bus.req_ready), 32'd1);
        chk({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        chk({tag, "_mem_addr"},      bus.mem_addr, 32'd0);
        chk({tag, "_fill_valid"},    32'(bus.fill_valid), 32'd0);
        chk({tag, "_fill_we"},       32'(bus.fill_we), 32'd0);
        chk({tag, "_done"},          32'(bus.done), 32'd0);
        chk({tag, "_fault"},         32'(bus.fault), 32'd0);
        chk({tag, "_fill_idx"},      32'(bus.fill_idx), 32'd0);
        chk({tag, "_fill_tag"},      32'(bus.fill_tag), 32'd0);
        chk({tag, "_fill_payload"},  bus.fill_payload, 32'd0);
    endtask

    // Drive one walk as requester and memory. Cycle 0 is the accept cycle;
    // results are left in the r_* variables. abort_at > 0 stops at that cycle.
    task automatic do_walk(input logic [19:0] vpn, input logic [19:0] root,
                           input logic [31:0] l1, input logic [31:0] l0,
                           input int stall, input int delay, input bit noise,
                           input bit hold_next, input logic [19:0] nvpn,
                           input logic [19:0] nroot, input int abort_at);
        int cnt, pend, stall_left, guard;
        bit seen, was_pend;
        logic [31:0] held;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.req_valid      = 1'b1;
        bus.req_vpn        = vpn;
        bus.root_ppn       = root;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = noise ? 1'($urandom % 2) : 1'b0;
        bus.mem_rdata      = $urandom;
        r_nreq = 0; r_lat = -1; r_addr1 = '0; r_addr2 = '0;
        r_stable = 1'b1; r_spur = 1'b0; r_busy_ok = 1'b1; r_overlap = 1'b0;
        r_timeout = 1'b0; r_fault = 1'b0; r_we = 1'b0; r_fv = 1'b0;
        r_payload = '0; r_idx = '0; r_tag = '0;
        pend = 0; stall_left = stall; seen = 1'b0; held = '0;
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == 1) begin
                if (hold_next) begin
                    bus.req_vpn  = nvpn;
                    bus.root_ppn = nroot;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (cnt == abort_at) break;
            if (bus.req_ready) r_busy_ok = 1'b0;
            was_pend = (pend > 0);
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    bus.mem_resp_valid = 1'b1;
                    bus.mem_rdata      = (r_nreq == 1) ? l1 : l0;
                end
            end else if (noise) begin
                // No read outstanding: a stray response must be ignored.
                bus.mem_resp_valid = 1'($urandom % 2);
            end
            if (bus.mem_req_valid) begin
                if (was_pend) r_overlap = 1'b1;
                if (!seen) begin
                    held = bus.mem_addr;
                    seen = 1'b1;
                end else if (bus.mem_addr !== held) begin
                    r_stable = 1'b0;
                end
                if (stall_left > 0) begin
                    bus.mem_req_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.mem_req_ready = 1'b1;
                    r_nreq++;
                    if (r_nreq == 1) r_addr1 = bus.mem_addr;
                    else             r_addr2 = bus.mem_addr;
                    pend = delay + 1;
                    stall_left = stall;
                    seen = 1'b0;
                end
            end else begin
                bus.mem_req_ready = noise ? 1'($urandom % 2) : 1'b1;
            end
            if (bus.done) begin
                r_lat     = cnt;
                r_fault   = bus.fault;
                r_we      = bus.fill_we;
                r_fv      = bus.fill_valid;
                r_payload = bus.fill_payload;
                r_idx     = bus.fill_idx;
                r_tag     = bus.fill_tag;
                break;
            end else if (bus.fill_valid || bus.fill_we || bus.fault) begin
                r_spur = 1'b1;
            end
        end
        bus.mem_resp_valid = 1'b0;
        if (r_lat < 0 && abort_at == 0) r_timeout = 1'b1;
    endtask

    task automatic check_walk(input string name, input logic [31:0] e_addr1,
                              input logic [31:0] e_addr2, input int e_nreq, input int e_lat,
                              input logic e_fault, input logic [31:0] e_payload,
                              input logic [5:0] e_idx, input logic [19:0] e_tag);
        chk({name, "_timeout"}, 32'(r_timeout), 32'd0);
        chk({name, "_nreq"},    32'(r_nreq), 32'(e_nreq));
        chk({name, "_addr1"},   r_addr1, e_addr1);
        if (e_nreq >= 2) chk({name, "_addr2"}, r_addr2, e_addr2);
        chk({name, "_latency"}, 32'(r_lat), 32'(e_lat));
        chk({name, "_fault"},   32'(r_fault), 32'(e_fault));
        chk({name, "_fill_we"}, 32'(r_we), 32'(!e_fault));
        chk({name, "_fill_valid"}, 32'(r_fv), 32'(!e_fault));
        if (!e_fault) begin
            chk({name, "_payload"}, r_payload, e_payload);
            chk({name, "_idx"},     32'(r_idx), 32'(e_idx));
            chk({name, "_tag"},     32'(r_tag), 32'(e_tag));
        end
        chk({name, "_addr_stable"},   32'(r_stable), 32'd1);
        chk({name, "_early_outputs"}, 32'(r_spur), 32'd0);
        chk({name, "_busy_ready"},    32'(r_busy_ok), 32'd1);
        chk({name, "_overlap"},       32'(r_overlap), 32'd0);
    endtask

    // Reference model: PTE class 0 = fault, 1 = pointer, 2 = leaf.
    function automatic int pte_kind(input int unsigned pte);
        int unsigned v, r, w, x;
        v = pte % 2; r = (pte / 2) % 2; w = (pte / 4) % 2; x = (pte / 8) % 2;
        if (v == 0 || (w == 1 && r == 0)) return 0;
        if (r == 0 && w == 0 && x == 0) return 1;
        return 2;
    endfunction

    task automatic model(input int unsigned vpn, input int unsigned root,
                         input int unsigned l1, input int unsigned l0,
                         input int stall, input int delay,
                         output logic [31:0] e_addr1, output logic [31:0] e_addr2,
                         output int e_nreq, output int e_lat, output logic e_fault,
                         output logic [31:0] e_payload);
        int unsigned vpn1, vpn0;
        int k1;
        vpn1 = vpn / 1024;
        vpn0 = vpn % 1024;
        e_addr1 = root * 4096 + vpn1 * 4;
        e_addr2 = '0;
        e_payload = '0;
        e_fault = 1'b0;
        e_nreq = 1;
        k1 = pte_kind(l1);
        if (k1 == 0) begin
            e_fault = 1'b1;
        end else if (k1 == 2) begin
            if (((l1 / 4096) % 1024) != 0) e_fault = 1'b1;
            else e_payload = (l1 / 4194304) * 4194304 + vpn0 * 4096 + l1 % 4096;
        end else begin
            e_nreq = 2;
            e_addr2 = (l1 / 4096) * 4096 + vpn0 * 4;
            if (pte_kind(l0) == 2) e_payload = l0;
            else e_fault = 1'b1;
        end
        e_lat = 1 + e_nreq * (2 + stall + delay);
    endtask

    function automatic logic [31:0] gen_pte();
        logic [31:0] p;
        p = $urandom;
        if ($urandom_range(0, 2) == 0) p[3:0] = 4'b0001;
        if ($urandom % 2 == 1) p[21:12] = '0;
        return p;
    endfunction

    initial begin
        logic [31:0] e_a1, e_a2, e_pl;
        int e_nr, e_lt, stl, dly;
        logic e_ft;
        logic [19:0] rv, rr;
        logic [31:0] p1, p0;
        bit quiet;

        vecs[0] = '{20'h12345, 20'h00080, 32'h00100001, 32'hABCDE00F, 0,
                    32'h00080120, 32'h00100D14, 2, 5, 1'b0, 32'hABCDE00F, 6'h05, 20'h12345};
        vecs[1] = '{20'h12345, 20'h00080, 32'h00400003, 32'h0, 0,
                    32'h00080120, 32'h0, 1, 3, 1'b0, 32'h00745003, 6'h05, 20'h12345};
        vecs[2] = '{20'h12345, 20'h00080, 32'h00401003, 32'h0, 0,
                    32'h00080120, 32'h0, 1, 3, 1'b1, 32'h0, 6'h0, 20'h0};
        vecs[3] = '{20'h12345, 20'h00080, 32'h00000000, 32'h0, 0,
                    32'h00080120, 32'h0, 1, 3, 1'b1, 32'h0, 6'h0, 20'h0};
        vecs[4] = '{20'h12345, 20'h00080, 32'h00100005, 32'h0, 0,
                    32'h00080120, 32'h0, 1, 3, 1'b1, 32'h0, 6'h0, 20'h0};
        vecs[5] = '{20'h12345, 20'h00080, 32'h00100001, 32'h00200001, 0,
                    32'h00080120, 32'h00100D14, 2, 5, 1'b1, 32'h0, 6'h0, 20'h0};
        vecs[6] = '{20'h12345, 20'h00080, 32'h00100001, 32'hABCDE00F, 4,
                    32'h00080120, 32'h00100D14, 2, 13, 1'b0, 32'hABCDE00F, 6'h05, 20'h12345};
        vecs[7] = '{20'hFFFFF, 20'h00001, 32'h00002001, 32'h7654300B, 0,
                    32'h00001FFC, 32'h00002FFC, 2, 5, 1'b0, 32'h7654300B, 6'h3F, 20'hFFFFF};
        vecs[8] = '{20'h00C01, 20'h00010, 32'h00033001, 32'h12345009, 0,
                    32'h0001000C, 32'h00033004, 2, 5, 1'b0, 32'h12345009, 6'h01, 20'h00C01};

        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_vpn = '0; bus.root_ppn = '0;
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
        #1;
        chk_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 9; i++) begin
            do_walk(vecs[i].vpn, vecs[i].root, vecs[i].l1, vecs[i].l0, vecs[i].stall, 0,
                    1'b0, 1'b0, 20'h0, 20'h0, 0);
            check_walk($sformatf("vec%0d", i), vecs[i].addr1, vecs[i].addr2, vecs[i].nreq,
                       vecs[i].lat, vecs[i].fault, vecs[i].payload, vecs[i].idx, vecs[i].tag);
        end

        // Back-to-back: request valid held high, second VPN presented while busy.
        do_walk(vecs[0].vpn, vecs[0].root, vecs[0].l1, vecs[0].l0, 0, 0,
                1'b0, 1'b1, vecs[7].vpn, vecs[7].root, 0);
        check_walk("b2b_first", vecs[0].addr1, vecs[0].addr2, vecs[0].nreq, vecs[0].lat,
                   vecs[0].fault, vecs[0].payload, vecs[0].idx, vecs[0].tag);
        @(posedge clk); #1;
        chk("b2b_ready_after_done", 32'(bus.req_ready), 32'd1);
        do_walk(vecs[7].vpn, vecs[7].root, vecs[7].l1, vecs[7].l0, 0, 0,
                1'b0, 1'b0, 20'h0, 20'h0, 0);
        check_walk("b2b_second", vecs[7].addr1, vecs[7].addr2, vecs[7].nreq, vecs[7].lat,
                   vecs[7].fault, vecs[7].payload, vecs[7].idx, vecs[7].tag);

        // Reset mid-walk in L0_WAIT (cycle 4), then a stale response.
        do_walk(vecs[0].vpn, vecs[0].root, vecs[0].l1, vecs[0].l0, 0, 0,
                1'b0, 1'b0, 20'h0, 20'h0, 4);
        reset = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata = vecs[0].l0;
        quiet = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.mem_resp_valid = 1'b0;
            if (bus.done || bus.fill_valid || bus.fill_we || bus.mem_req_valid || !bus.req_ready)
                quiet = 1'b0;
        end
        chk("midreset_stale_resp_ignored", 32'(quiet), 32'd1);
        do_walk(vecs[0].vpn, vecs[0].root, vecs[0].l1, vecs[0].l0, 0, 0,
                1'b0, 1'b0, 20'h0, 20'h0, 0);
        check_walk("after_reset", vecs[0].addr1, vecs[0].addr2, vecs[0].nreq, vecs[0].lat,
                   vecs[0].fault, vecs[0].payload, vecs[0].idx, vecs[0].tag);

        // Randomized walks against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv  = 20'($urandom);
            rr  = 20'($urandom);
            p1  = gen_pte();
            p0  = gen_pte();
            stl = $urandom_range(0, 3);
            dly = $urandom_range(0, 2);
            model(32'(rv), 32'(rr), p1, p0, stl, dly, e_a1, e_a2, e_nr, e_lt, e_ft, e_pl);
            do_walk(rv, rr, p1, p0, stl, dly, 1'b1, 1'b0, 20'h0, 20'h0, 0);
            check_walk($sformatf("rand%0d", i), e_a1, e_a2, e_nr, e_lt, e_ft, e_pl,
                       rv[5:0], rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/page_table_walker.md
# page_table_walker

Two-level hardware page-table walker for the MMU refill path. On a translation miss it reads the level-1 and, if needed, level-0 page-table entries from memory over a single-outstanding read port. It decodes each PTE and either writes one fill entry (tag, idx, payload) into the translation tag RAM or reports a page fault. It sits between the tag-RAM miss logic and the memory/bus read port.

## Interface

**Parameters**
- TAG_RAM_ADDR_WIDTH, 6, index width of the tag RAM; fill index is vpn[TAG_RAM_ADDR_WIDTH-1:0]
- TAG_WIDTH, 20, tag width; must equal 20 (full VPN)
- PAYLOAD_WIDTH, 32, fill payload width; must equal 32

**Ports**
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  miss request valid
- req_ready  out  1  walker idle, request accepted when valid && ready
- req_vpn  in  20  missing VPN; vpn1 = req_vpn[19:10], vpn0 = req_vpn[9:0]
- root_ppn  in  20  root page-table PPN, sampled at request acceptance
- mem_req_valid  out  1  PTE read request
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  32  PTE byte address
- mem_resp_valid  in  1  read data valid
- mem_rdata  in  32  PTE: [31:12] PPN, [3] X, [2] W, [1] R, [0] V
- fill_valid  out  1  tag-RAM valid_i strobe
- fill_we  out  1  tag-RAM write enable
- fill_idx  out  TAG_RAM_ADDR_WIDTH  tag-RAM index
- fill_tag  out  TAG_WIDTH  tag-RAM tag (VPN)
- fill_payload  out  PAYLOAD_WIDTH  {leaf_ppn[19:0], pte[11:0]}
- done  out  1  one-cycle walk-complete pulse
- fault  out  1  qualifies done: page fault, no fill

## Operation

- **States:** IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, DONE.
- **IDLE:** req_ready = 1. On accept, latch req_vpn and root_ppn, go to L1_REQ.
- **L1_REQ:** mem_req_valid = 1, mem_addr = {root_ppn, vpn1, 2'b00}. Go to L1_WAIT on mem_req_ready. Address is held stable while ready is low.
- **L0_REQ:** mem_addr = {ptr_ppn, vpn0, 2'b00}, with ptr_ppn = PPN of the L1 PTE. Same handshake; go to L0_WAIT.
- **WAIT states:** ignore mem_resp_valid outside WAIT states. On mem_resp_valid, decode mem_rdata in the same cycle:
  - !V, or W && !R → fault → DONE.
  - V && !R && !W && !X: at L1, pointer → L0_REQ. At L0 → fault → DONE.
  - Leaf (V && (R || X)) at L1: PTE[21:12] != 0 is a misaligned-superpage fault → DONE. Otherwise leaf_ppn = {PTE[31:22], vpn0} → DONE.
  - Leaf at L0: leaf_ppn = PTE[31:12] → DONE.
- **DONE (one cycle):**
  - done = 1 and fault = fault flag.
  - If no fault: fill_valid = fill_we = 1, fill_idx = vpn[TAG_RAM_ADDR_WIDTH-1:0], fill_tag = vpn, fill_payload = {leaf_ppn, pte[11:0]}.
  - If fault: fill_valid = fill_we = 0.
  - Next state IDLE.
- Exactly one memory request is outstanding at any time. mem_req_valid is never asserted in WAIT states.

## Timing

- **Reset (async):** state = IDLE. req_ready = 1. mem_req_valid, fill_valid, fill_we, done, fault = 0. mem_addr, fill_idx, fill_tag, fill_payload = 0.
- **Reset mid-walk:** walk is abandoned immediately with no fill and no done. A memory response arriving after reset is ignored in IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from mem_* inputs to outputs.
- **Latency (mem_req_ready tied 1, response in the cycle after the request is accepted; accept at cycle 0):**
  - Superpage/fault at L1: done at cycle 3.
  - Two-level: done at cycle 5.
- req_ready is low from the cycle after accept through DONE. The earliest next accept is the cycle after DONE.
- A request presented while busy is held by the requester. It is not dropped or queued.

## Test plan

- **Two-level hit:** root_ppn=0x00080, vpn=0x12345.
  - Expect mem_addr 0x00080120; respond 0x00100001.
  - Expect mem_addr 0x00100D14; respond 0xABCDE00F.
  - Expect done=1, fault=0, fill_we=1, fill_idx=0x05, fill_tag=0x12345, fill_payload=0xABCDE00F, at cycle 5.
- **Superpage:** L1 response 0x00400003 → done at cycle 3, fill_payload=0x00745003, no second mem request.
- **Faults, each with done=1, fault=1, fill_we=0:**
  - L1 PTE 0x00401003 (misaligned).
  - L1 PTE 0x00000000 (invalid).
  - L1 PTE 0x00100005 (W without R).
  - L0 PTE 0x00200001 (pointer at L0).
- **Backpressure:** hold mem_req_ready=0 for 4 cycles in L1_REQ → mem_req_valid=1 and mem_addr=0x00080120 stable throughout; walk completes normally afterward.
- **Reset mid-walk:** assert reset in L0_WAIT → outputs at reset values within the same cycle. A following mem_resp_valid produces no fill or done. A new request then walks correctly.
- **Back-to-back:** req_valid held high with two VPNs → second accept occurs exactly one cycle after the first done. No request is lost.
